filterbank_sequencer: RTL and testbench
=======================================

// Module: filterbank_sequencer
// PURPOSE
// - Schedules one shared biquad engine across all vocoder channels and stages for each audio frame.
// - Sits between sample capture (mic/line-in valid) and the filterbank datapath, running at clk_fb rate.
// - Per accepted frame it issues MOD, ENV, then CAR for every enabled channel, then pulses valid_out to the mixer.
// - It also latches the frame's carrier and modulator samples, drops overrun frames and aborts on engine timeout.
// PARAMETERS
// - N_FILTERS       16  number of vocoder channels (>=1)
// - SAMPLE_WIDTH    24  signed sample width for carrier/modulator
// - TIMEOUT_CYCLES  64  max WAIT cycles per engine op before abort (>=2)
// PORTS
// - clk_in             in   1               filterbank clock
// - rst_in             in   1               synchronous active-high reset
// - valid_in           in   1               new frame strobe (1 cycle)
// - carrier_sample_in  in   SAMPLE_WIDTH    signed synth sample
// - modulator_sample_in in  SAMPLE_WIDTH    signed mic/line sample
// - ch_mask_in         in   N_FILTERS       per-channel enable; bit k=1 runs channel k
// - engine_done_in     in   1               engine op complete (1 cycle)
// - engine_start_out   out  1               start engine op (1-cycle pulse)
// - ch_out             out  $clog2(N_FILTERS) channel of current op
// - stage_out          out  2               0=MOD 1=ENV 2=CAR
// - carrier_hold_out   out  SAMPLE_WIDTH    latched carrier, stable all frame
// - modulator_hold_out out  SAMPLE_WIDTH    latched modulator, stable all frame
// - valid_out          out  1               frame complete (1-cycle pulse)
// - busy_out           out  1               state != IDLE
// - overrun_out        out  1               1-cycle pulse: valid_in dropped
// - error_out          out  1               sticky: engine timeout occurred
// - overrun_count_out  out  16              dropped-frame count (see CONFIGURATION)
// BEHAVIOUR
// - Interface: one clock (clk_in); rst_in is synchronous and active-high.
// - Reset: state=IDLE. All outputs 0, error_out cleared, counters 0. Reset mid-frame aborts the frame; no valid_out.
// - FSM states: IDLE, SEEK, ISSUE, WAIT, DONE.
// - IDLE: on valid_in, latch both samples and ch_mask_in; ch=0, stage=0; go to SEEK.
// - SEEK: if ch==N_FILTERS, go to DONE. Else if latched mask[ch]==0, ch++ and stay in SEEK. Else go to ISSUE.
// - ISSUE: engine_start_out=1 for this cycle; clear the timeout counter; go to WAIT.
// - WAIT, engine_done_in seen: if stage==2, set stage=0, ch++, go to SEEK; else stage++, go to ISSUE.
// - WAIT, timeout: if the counter reaches TIMEOUT_CYCLES with no done, set error_out=1 and go to IDLE. No valid_out.
// - DONE: valid_out=1 for one cycle; go to IDLE.
// - ch_out and stage_out are registered and stable from ISSUE through WAIT.
// - engine_done_in outside WAIT is ignored. Done in the ISSUE cycle is ignored, so engine latency must be >=1.
// - valid_in when state!=IDLE (including the DONE cycle): frame dropped, overrun_out pulses, latches unchanged.
// - Latency, all channels enabled, done exactly L cycles after start: valid_out asserts N*(3L+4)+2 cycles after valid_in.
// - All-zero mask: no starts issued; valid_out asserts N+2 cycles after valid_in.
// - The latched mask is used for the whole frame; mid-frame ch_mask_in changes take effect next frame.
// - error_out is cleared only by rst_in. The sequencer keeps accepting frames after an error.
// CONFIGURATION
// - Macro FBSEQ_OVERRUN_CNT_EN.
// - Defined: overrun_count_out increments on each overrun_out pulse and saturates at 16'hFFFF; cleared by rst_in.
// - Not defined: overrun_count_out is tied to 0 and no counter logic is built.
// TESTING
// - N=4, L=1, mask=4'hF, valid_in once -> 12 starts, order (ch,stage) (0,0)(0,1)(0,2)(1,0)..(3,2); valid_out 30 cycles after valid_in.
// - N=4, L=1, mask=4'b0101 -> starts only for ch 0 and 2 (6 starts); valid_out exactly once.
// - mask=0 -> zero starts; valid_out 6 cycles after valid_in (N=4).
// - Second valid_in 5 cycles into a frame -> overrun_out pulses once; hold outputs keep the first samples; with the macro, count=1.
// - Engine never returns done, TIMEOUT_CYCLES=64 -> error_out set after 64 WAIT cycles; no valid_out; next frame completes normally with error_out still 1.
// - rst_in asserted during WAIT of ch 2 -> all outputs 0 the next cycle; no valid_out; the next valid_in restarts at ch 0, stage 0.

Source files
------------

// File: rtl/filterbank_sequencer_if.sv
// Handshake and data bundle between capture, the shared biquad engine
// and the filterbank sequencer.
interface filterbank_sequencer_if #(
    parameter int N_FILTERS    = 16,
    parameter int SAMPLE_WIDTH = 24
);
    localparam int CW = (N_FILTERS > 1) ? $clog2(N_FILTERS) : 1;

    logic                           valid_in;
    logic signed [SAMPLE_WIDTH-1:0] carrier_sample_in;
    logic signed [SAMPLE_WIDTH-1:0] modulator_sample_in;
    logic [N_FILTERS-1:0]           ch_mask_in;
    logic                           engine_done_in;
    logic                           engine_start_out;
    logic [CW-1:0]                  ch_out;
    logic [1:0]                     stage_out;
    logic signed [SAMPLE_WIDTH-1:0] carrier_hold_out;
    logic signed [SAMPLE_WIDTH-1:0] modulator_hold_out;
    logic                           valid_out;
    logic                           busy_out;
    logic                           overrun_out;
    logic                           error_out;
    logic [15:0]                    overrun_count_out;

    modport master (
        output valid_in, carrier_sample_in, modulator_sample_in,
        output ch_mask_in, engine_done_in,
        input  engine_start_out, ch_out, stage_out,
        input  carrier_hold_out, modulator_hold_out,
        input  valid_out, busy_out, overrun_out, error_out,
        input  overrun_count_out
    );

    modport slave (
        input  valid_in, carrier_sample_in, modulator_sample_in,
        input  ch_mask_in, engine_done_in,
        output engine_start_out, ch_out, stage_out,
        output carrier_hold_out, modulator_hold_out,
        output valid_out, busy_out, overrun_out, error_out,
        output overrun_count_out
    );
endinterface

// File: rtl/filterbank_sequencer.sv
// Shares one biquad engine across all vocoder channels (MOD, ENV, CAR).
// Optional dropped-frame counter: define FBSEQ_OVERRUN_CNT_EN.
module filterbank_sequencer #(
    parameter int N_FILTERS      = 16,
    parameter int SAMPLE_WIDTH   = 24,
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic clk_in,
    input logic rst_in,
    filterbank_sequencer_if.slave bus
);
    localparam int CW = (N_FILTERS > 1) ? $clog2(N_FILTERS) : 1;
    localparam int SW = $clog2(N_FILTERS + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE, SEEK, ISSUE, WAIT, DONE
    } state_t;

    state_t state, next;

    logic [SW-1:0]                  ch;
    logic [1:0]                     stage;
    logic [TW-1:0]                  tcnt;
    logic [N_FILTERS-1:0]           mask;
    logic signed [SAMPLE_WIDTH-1:0] car;
    logic signed [SAMPLE_WIDTH-1:0] modl;
    logic                           error;
    logic                           overrun;
    logic [N_FILTERS:0]             mask_ext;

    logic accept, ch_inc, stage_inc, wrap;
    logic tcnt_inc, timeout;

    // Extra zero bit lets ch==N_FILTERS index safely.
    assign mask_ext = {1'b0, mask};

    always_ff @(posedge clk_in) begin
        if (rst_in) state <= IDLE;
        else        state <= next;
    end

    always_comb begin
        next      = state;
        accept    = 1'b0;
        ch_inc    = 1'b0;
        stage_inc = 1'b0;
        wrap      = 1'b0;
        tcnt_inc  = 1'b0;
        timeout   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.valid_in) begin
                    accept = 1'b1;
                    next   = SEEK;
                end
            end
            SEEK: begin
                if (ch == SW'(N_FILTERS)) next = DONE;
                else if (!mask_ext[ch])   ch_inc = 1'b1;
                else                      next = ISSUE;
            end
            ISSUE: next = WAIT;
            WAIT: begin
                if (bus.engine_done_in) begin
                    if (stage == 2'd2) begin
                        wrap = 1'b1;
                        next = SEEK;
                    end else begin
                        stage_inc = 1'b1;
                        next      = ISSUE;
                    end
                end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    timeout = 1'b1;
                    next    = IDLE;
                end else begin
                    tcnt_inc = 1'b1;
                end
            end
            DONE: next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ch      <= '0;
            stage   <= '0;
            tcnt    <= '0;
            mask    <= '0;
            car     <= '0;
            modl    <= '0;
            error   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= bus.valid_in && (state != IDLE);
            if (accept) begin
                car   <= bus.carrier_sample_in;
                modl  <= bus.modulator_sample_in;
                mask  <= bus.ch_mask_in;
                ch    <= '0;
                stage <= '0;
            end
            if (ch_inc || wrap) ch <= ch + SW'(1);
            if (wrap)           stage <= '0;
            if (stage_inc)      stage <= stage + 2'd1;
            if (state == ISSUE) tcnt <= '0;
            else if (tcnt_inc)  tcnt <= tcnt + TW'(1);
            if (timeout)        error <= 1'b1;
        end
    end

`ifdef FBSEQ_OVERRUN_CNT_EN
    logic [15:0] ovr_cnt;

    always_ff @(posedge clk_in) begin
        if (rst_in)
            ovr_cnt <= '0;
        else if (overrun && ovr_cnt != 16'hFFFF)
            ovr_cnt <= ovr_cnt + 16'd1;
    end

    assign bus.overrun_count_out = ovr_cnt;
`else
    assign bus.overrun_count_out = '0;
`endif

    assign bus.engine_start_out   = (state == ISSUE);
    assign bus.valid_out          = (state == DONE);
    assign bus.busy_out           = (state != IDLE);
    assign bus.ch_out             = ch[CW-1:0];
    assign bus.stage_out          = stage;
    assign bus.carrier_hold_out   = car;
    assign bus.modulator_hold_out = modl;
    assign bus.overrun_out        = overrun;
    assign bus.error_out          = error;
endmodule

// File: tb/tb_filterbank_sequencer.sv
// Directed bench for filterbank_sequencer: N=4, engine latency 1,
// timeout 64.
module tb_filterbank_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;

    filterbank_sequencer_if #(.N_FILTERS(4), .SAMPLE_WIDTH(24)) bus ();

    filterbank_sequencer #(
        .N_FILTERS(4),
        .SAMPLE_WIDTH(24),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

`ifdef FBSEQ_OVERRUN_CNT_EN
    localparam logic [15:0] EXP_CNT = 16'd1;
`else
    localparam logic [15:0] EXP_CNT = 16'd0;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    int cyc = 0;
    int nst = 0;
    int nvalid = 0;
    int nover = 0;
    int valid_cyc = 0;
    int start_cyc = 0;
    int vin_cyc = 0;
    logic [1:0] log_ch [64];
    logic [1:0] log_st [64];

    logic eng_en = 1'b1;
    logic pend = 1'b0;

    // Engine model: done one cycle after start.
    always @(negedge clk) begin
        bus.engine_done_in = eng_en && pend;
        pend = bus.engine_start_out;
    end

    always @(posedge clk) begin
        if (bus.engine_start_out) begin
            if (nst < 64) begin
                log_ch[nst] = bus.ch_out;
                log_st[nst] = bus.stage_out;
            end
            if (nst == 0) start_cyc = cyc;
            nst++;
        end
        if (bus.valid_out) begin
            nvalid++;
            valid_cyc = cyc;
        end
        if (bus.overrun_out) nover++;
        cyc++;
    end

    task automatic pulse_valid(input logic [3:0] m,
                               input logic [23:0] c,
                               input logic [23:0] md);
        bus.ch_mask_in          = m;
        bus.carrier_sample_in   = c;
        bus.modulator_sample_in = md;
        bus.valid_in            = 1'b1;
        vin_cyc                 = cyc;
        @(negedge clk);
        bus.valid_in = 1'b0;
    endtask

    task automatic wait_valid(input int target, input int bound);
        for (int i = 0; i < bound; i++) begin
            if (nvalid >= target) break;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++;
        if (bus.busy_out !== 1'b0 || bus.valid_out !== 1'b0 ||
            bus.engine_start_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl busy=%b valid=%b start=%b want 000",
                     bus.busy_out, bus.valid_out, bus.engine_start_out);
        end
        n_chk++;
        if (bus.error_out !== 1'b0 || bus.overrun_out !== 1'b0 ||
            bus.overrun_count_out !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_flags err=%b ovr=%b cnt=%0d want 0",
                     bus.error_out, bus.overrun_out,
                     bus.overrun_count_out);
        end
        n_chk++;
        if (bus.carrier_hold_out !== 24'd0 ||
            bus.modulator_hold_out !== 24'd0 ||
            bus.ch_out !== 2'd0 || bus.stage_out !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_hold car=%h mod=%h ch=%0d st=%0d want 0",
                     bus.carrier_hold_out, bus.modulator_hold_out,
                     bus.ch_out, bus.stage_out);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_mask;
        nst = 0;
        nvalid = 0;
        pulse_valid(4'hF, 24'h123456, 24'hABCDEF);
        wait_valid(1, 100);
        n_chk++;
        if (nvalid != 1) begin
            n_fail++;
            $display("FAIL full_valid got %0d want 1", nvalid);
        end
        n_chk++;
        if (valid_cyc - vin_cyc != 30) begin
            n_fail++;
            $display("FAIL full_latency got %0d want 30",
                     valid_cyc - vin_cyc);
        end
        n_chk++;
        if (nst != 12) begin
            n_fail++;
            $display("FAIL full_starts got %0d want 12", nst);
        end
        for (int i = 0; i < 12; i++) begin
            n_chk++;
            if (log_ch[i] !== 2'(i / 3) || log_st[i] !== 2'(i % 3)) begin
                n_fail++;
                $display("FAIL full_order[%0d] got (%0d,%0d) want (%0d,%0d)",
                         i, log_ch[i], log_st[i], i / 3, i % 3);
            end
        end
        n_chk++;
        if (bus.carrier_hold_out !== 24'h123456 ||
            bus.modulator_hold_out !== 24'hABCDEF) begin
            n_fail++;
            $display("FAIL full_hold car=%h mod=%h want 123456/abcdef",
                     bus.carrier_hold_out, bus.modulator_hold_out);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_sparse_mask;
        nst = 0;
        nvalid = 0;
        pulse_valid(4'b0101, 24'h000010, 24'hFFFFF0);
        wait_valid(1, 100);
        repeat (3) @(negedge clk);
        n_chk++;
        if (nst != 6 || nvalid != 1) begin
            n_fail++;
            $display("FAIL sparse_counts starts=%0d valid=%0d want 6/1",
                     nst, nvalid);
        end
        for (int i = 0; i < 6; i++) begin
            n_chk++;
            if (log_ch[i] !== ((i < 3) ? 2'd0 : 2'd2) ||
                log_st[i] !== 2'(i % 3)) begin
                n_fail++;
                $display("FAIL sparse_order[%0d] got (%0d,%0d)",
                         i, log_ch[i], log_st[i]);
            end
        end
        n_chk++;
        if (valid_cyc - vin_cyc != 18) begin
            n_fail++;
            $display("FAIL sparse_latency got %0d want 18",
                     valid_cyc - vin_cyc);
        end
    endtask

    task automatic test_zero_mask;
        nst = 0;
        nvalid = 0;
        pulse_valid(4'h0, 24'h000001, 24'h000002);
        wait_valid(1, 40);
        n_chk++;
        if (nst != 0 || nvalid != 1) begin
            n_fail++;
            $display("FAIL zero_counts starts=%0d valid=%0d want 0/1",
                     nst, nvalid);
        end
        n_chk++;
        if (valid_cyc - vin_cyc != 6) begin
            n_fail++;
            $display("FAIL zero_latency got %0d want 6",
                     valid_cyc - vin_cyc);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_overrun;
        nst = 0;
        nvalid = 0;
        nover = 0;
        pulse_valid(4'hF, 24'h111111, 24'h222222);
        repeat (4) @(negedge clk);
        pulse_valid(4'h0, 24'h333333, 24'h444444);
        wait_valid(1, 100);
        repeat (3) @(negedge clk);
        n_chk++;
        if (nover != 1) begin
            n_fail++;
            $display("FAIL ovr_pulses got %0d want 1", nover);
        end
        n_chk++;
        if (nvalid != 1 || nst != 12) begin
            n_fail++;
            $display("FAIL ovr_frame valid=%0d starts=%0d want 1/12",
                     nvalid, nst);
        end
        n_chk++;
        if (bus.carrier_hold_out !== 24'h111111 ||
            bus.modulator_hold_out !== 24'h222222) begin
            n_fail++;
            $display("FAIL ovr_hold car=%h mod=%h want 111111/222222",
                     bus.carrier_hold_out, bus.modulator_hold_out);
        end
        n_chk++;
        if (bus.overrun_count_out !== EXP_CNT) begin
            n_fail++;
            $display("FAIL ovr_count got %0d want %0d",
                     bus.overrun_count_out, EXP_CNT);
        end
    endtask

    task automatic test_timeout;
        eng_en = 1'b0;
        nst = 0;
        nvalid = 0;
        pulse_valid(4'hF, 24'h0000AA, 24'h0000BB);
        for (int i = 0; i < 20 && nst == 0; i++) @(negedge clk);
        n_chk++;
        if (nst != 1) begin
            n_fail++;
            $display("FAIL to_start got %0d want 1", nst);
        end
        for (int i = 0; i < 100 && cyc < start_cyc + 64; i++)
            @(negedge clk);
        n_chk++;
        if (bus.error_out !== 1'b0 || bus.busy_out !== 1'b1) begin
            n_fail++;
            $display("FAIL to_early err=%b busy=%b want 0/1",
                     bus.error_out, bus.busy_out);
        end
        @(negedge clk);
        n_chk++;
        if (bus.error_out !== 1'b1 || bus.busy_out !== 1'b0 ||
            nvalid != 0) begin
            n_fail++;
            $display("FAIL to_abort err=%b busy=%b valid=%0d want 1/0/0",
                     bus.error_out, bus.busy_out, nvalid);
        end
        eng_en = 1'b1;
        repeat (2) @(negedge clk);
        pulse_valid(4'h3, 24'h000005, 24'h000006);
        wait_valid(1, 100);
        n_chk++;
        if (nvalid != 1 || bus.error_out !== 1'b1) begin
            n_fail++;
            $display("FAIL to_recover valid=%0d err=%b want 1/1",
                     nvalid, bus.error_out);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        nst = 0;
        nvalid = 0;
        pulse_valid(4'hF, 24'h0ABCDE, 24'h012345);
        for (int i = 0; i < 50 && nst < 7; i++) @(negedge clk);
        n_chk++;
        if (nst != 7 || log_ch[6] !== 2'd2) begin
            n_fail++;
            $display("FAIL rm_reach starts=%0d ch=%0d want 7/2",
                     nst, log_ch[6]);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_chk++;
        if (bus.busy_out !== 1'b0 || bus.error_out !== 1'b0 ||
            bus.engine_start_out !== 1'b0 || bus.valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL rm_ctrl busy=%b err=%b start=%b valid=%b",
                     bus.busy_out, bus.error_out,
                     bus.engine_start_out, bus.valid_out);
        end
        n_chk++;
        if (bus.carrier_hold_out !== 24'd0 || bus.ch_out !== 2'd0 ||
            bus.stage_out !== 2'd0 ||
            bus.overrun_count_out !== 16'd0) begin
            n_fail++;
            $display("FAIL rm_state car=%h ch=%0d st=%0d cnt=%0d want 0",
                     bus.carrier_hold_out, bus.ch_out,
                     bus.stage_out, bus.overrun_count_out);
        end
        repeat (40) @(negedge clk);
        n_chk++;
        if (nvalid != 0) begin
            n_fail++;
            $display("FAIL rm_novalid got %0d want 0", nvalid);
        end
        nst = 0;
        pulse_valid(4'hF, 24'h000777, 24'h000888);
        wait_valid(1, 100);
        n_chk++;
        if (nst != 12 || log_ch[0] !== 2'd0 || log_st[0] !== 2'd0) begin
            n_fail++;
            $display("FAIL rm_restart starts=%0d first=(%0d,%0d) want 12/(0,0)",
                     nst, log_ch[0], log_st[0]);
        end
    endtask

    initial begin
        bus.valid_in            = 1'b0;
        bus.carrier_sample_in   = '0;
        bus.modulator_sample_in = '0;
        bus.ch_mask_in          = '0;
        bus.engine_done_in      = 1'b0;
        @(negedge clk);
        test_reset();
        test_full_mask();
        test_sparse_mask();
        test_zero_mask();
        test_overrun();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
